video_pixel_feeder: RTL and testbench
=====================================

# video_pixel_feeder

Pixel-stream feeder sitting directly upstream of the VGA timing generator's RGB output path, in the pixel clock domain. It pops pixels from a valid/ready stream (typically the framebuffer read FIFO) exactly when the timing generator signals an active display pixel. It aligns each stream frame to the raster using a start-of-frame marker, blacks out and resynchronises on underflow or frame-length mismatch, and reports lock and error status.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- DW, 24, pixel width (RGB 8:8:8)

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- pixel_rst  in  1  asynchronous, active-low reset
- in_data  in  DW  pixel at stream head
- in_sof  in  1  head pixel is pixel (0,0) of a frame
- in_valid  in  1  stream head valid
- in_ready  out  1  pop strobe; transfer when in_valid && in_ready (combinational)
- tim_de  in  1  timing generator: current cycle is an active display pixel
- tim_first  in  1  with tim_de: current pixel is (0,0); never high without tim_de
- rgb  out  DW  registered pixel to panel; 0 (black) when not driven by a popped pixel
- rgb_de  out  1  registered copy of tim_de
- locked  out  1  high while in RUN
- err_pulse  out  1  one-cycle pulse per detected error (registered)
- err_count  out  8  saturating error count (stops at 255)

## Operation
- NPIX = HDISP*VDISP; pix_cnt width $clog2(NPIX), counts pixels popped in current frame, wraps NPIX-1 -> 0.
- pop = in_valid && in_ready.
- States:
  - SYNC: in_ready = 1 if head is not SOF (discard stale pixels); in_ready = 0 when in_valid && in_sof -> WAIT_FRAME. pix_cnt held 0.
  - WAIT_FRAME: in_ready = tim_first (the SOF pixel is popped on tim_first). On tim_first: if in_valid -> RUN, pix_cnt <= 1; if !in_valid -> underflow error, -> SYNC.
  - RUN: with tim_de high:
    - in_valid, !in_sof, !(tim_first && pix_cnt!=0): pop, pix_cnt++ (wrap).
    - in_valid, in_sof, pix_cnt==0 (tim_first asserted by construction): pop, pix_cnt <= 1.
    - !in_valid: underflow error, no pop -> SYNC.
    - in_valid && in_sof && pix_cnt!=0 (stream frame short): error, no pop -> WAIT_FRAME.
    - tim_first && pix_cnt!=0 (stream frame long): error, no pop -> SYNC.
    - tim_first && pix_cnt==0 && !in_sof (SOF missing): error, no pop -> SYNC.
  - tim_de low in RUN: in_ready = 0, no state change.
- Error priority when several apply in one cycle: underflow > short > long/missing SOF; exactly one err_pulse per cycle.
- err_count increments on each error, saturates at 255; cleared only by reset.
- rgb <= pop ? in_data : 0; rgb_de <= tim_de; locked = (state == RUN).

## Timing
- Reset values: state SYNC, pix_cnt 0, rgb 0, rgb_de 0, locked 0, err_pulse 0, err_count 0. in_ready after reset follows SYNC rule combinationally.
- Reset assertion mid-frame takes effect immediately (async); outputs go to reset values the same instant; no pixels popped while pixel_rst low.
- Latency: pixel popped in cycle n appears on rgb in cycle n+1 together with rgb_de = tim_de of cycle n.
- err_pulse asserted the cycle after the error condition; locked changes the cycle after the transition.
- Every error cycle that has tim_de high outputs black (rgb = 0, rgb_de = 1) in the following cycle.
- Sustained throughput: one pixel per cycle while tim_de high; no bubble needed at frame wrap.

## Test plan
(Tests run with HDISP=4, VDISP=2, NPIX=8.)
- Nominal: stream always valid, frames of 8 pixels with SOF on first, data 0x000001..0x000008; two raster frames -> rgb shows 1..8 each frame one cycle after tim_de, locked high from the cycle after first tim_first, err_count 0.
- Stale discard: 3 non-SOF pixels precede first SOF -> all 3 popped in SYNC, never on rgb; first frame output 1..8.
- Underflow: in_valid dropped for one tim_de cycle at pixel 5 -> rgb 0 for that pixel, err_pulse once, err_count 1, locked low, relock on next frame's SOF at tim_first.
- Short stream frame (7 pixels then SOF) -> error at 8th display pixel, black, state WAIT_FRAME, SOF pixel popped at next tim_first, locked again, err_count 1.
- Long stream frame (9 pixels) -> error at tim_first with pix_cnt 0 but head non-SOF; ninth pixel discarded in SYNC, relock on following SOF.
- Reset mid-frame at pixel 3 and 300 forced errors -> all outputs 0 during reset; err_count saturates at 255 before reset, reads 0 after.

Source files
------------

// File: rtl/video_pixel_feeder.sv
// Pixel-stream feeder: pops stream pixels on active display cycles, aligns stream frames
// to the raster via start-of-frame markers, blanks and resynchronises on stream errors.
module video_pixel_feeder #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int DW    = 24
) (
    input  logic          pixel_clk,
    input  logic          pixel_rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_sof,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          tim_de,
    input  logic          tim_first,
    output logic [DW-1:0] rgb,
    output logic          rgb_de,
    output logic          locked,
    output logic          err_pulse,
    output logic [7:0]    err_count
);

    localparam int NPIX = HDISP * VDISP;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

    typedef enum logic [1:0] {
        SYNC,
        WAIT_FRAME,
        RUN
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] pix_cnt, pix_cnt_nxt;
    logic          rdy, pop, show, err;

    logic [DW-1:0] rgb_p1;
    logic          vld_p1;
    logic          err_p1;
    logic [7:0]    err_cnt_p1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return (v == LAST) ? '0 : v + CW'(1);
    endfunction

    always_comb begin
        state_nxt   = state;
        pix_cnt_nxt = pix_cnt;
        rdy         = 1'b0;
        err         = 1'b0;
        case (state)
            SYNC: begin
                // Drain stale pixels until a frame start sits at the head.
                pix_cnt_nxt = '0;
                rdy         = !(in_valid && in_sof);
                if (in_valid && in_sof)
                    state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                pix_cnt_nxt = '0;
                rdy         = tim_first;
                if (tim_first) begin
                    if (in_valid) begin
                        state_nxt   = RUN;
                        pix_cnt_nxt = wrap_inc('0);
                    end else begin
                        err       = 1'b1;
                        state_nxt = SYNC;
                    end
                end
            end
            RUN: begin
                if (tim_de) begin
                    // Checks ordered by error priority: underflow, short, long/missing SOF.
                    if (!in_valid) begin
                        err         = 1'b1;
                        state_nxt   = SYNC;
                        pix_cnt_nxt = '0;
                    end else if (in_sof && pix_cnt != '0) begin
                        err         = 1'b1;
                        state_nxt   = WAIT_FRAME;
                        pix_cnt_nxt = '0;
                    end else if (tim_first && (pix_cnt != '0 || !in_sof)) begin
                        err         = 1'b1;
                        state_nxt   = SYNC;
                        pix_cnt_nxt = '0;
                    end else begin
                        rdy         = 1'b1;
                        pix_cnt_nxt = wrap_inc(pix_cnt);
                    end
                end
            end
            default: begin
                state_nxt   = SYNC;
                pix_cnt_nxt = '0;
            end
        endcase
    end

    assign in_ready = pixel_rst && rdy;
    assign pop      = in_valid && in_ready;
    assign show     = pop && (state != SYNC);
    assign locked   = (state == RUN);

    always_ff @(posedge pixel_clk or negedge pixel_rst) begin
        if (!pixel_rst) begin
            state   <= SYNC;
            pix_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pix_cnt <= pix_cnt_nxt;
        end
    end

    // Stage p1: registered pixel, display enable and error status.
    always_ff @(posedge pixel_clk or negedge pixel_rst) begin
        if (!pixel_rst) begin
            rgb_p1     <= '0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            err_cnt_p1 <= 8'd0;
        end else begin
            rgb_p1 <= show ? in_data : '0;
            vld_p1 <= tim_de;
            err_p1 <= err;
            if (err)
                err_cnt_p1 <= sat_inc8(err_cnt_p1);
        end
    end

    assign rgb       = rgb_p1;
    assign rgb_de    = vld_p1;
    assign err_pulse = err_p1;
    assign err_count = err_cnt_p1;

endmodule

// File: tb/tb_video_pixel_feeder.sv
// Directed bench for video_pixel_feeder on a 4x2 raster: nominal, stale discard,
// underflow, short/long stream frames, error saturation and asynchronous reset.
module tb_video_pixel_feeder;

    localparam int HDISP = 4;
    localparam int VDISP = 2;
    localparam int DW    = 24;

    logic          clk = 1'b0;
    logic          pixel_rst;
    logic [DW-1:0] in_data;
    logic          in_sof, in_valid, in_ready;
    logic          tim_de, tim_first;
    logic [DW-1:0] rgb;
    logic          rgb_de, locked, err_pulse;
    logic [7:0]    err_count;

    video_pixel_feeder #(.HDISP(HDISP), .VDISP(VDISP), .DW(DW)) dut (
        .pixel_clk (clk),
        .pixel_rst (pixel_rst),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tim_de    (tim_de),
        .tim_first (tim_first),
        .rgb       (rgb),
        .rgb_de    (rgb_de),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [24:0] smem [0:31];
    int slen = 0;
    int head = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr();
        slen = 0;
        head = 0;
    endtask

    task automatic push(input int sof, input logic [23:0] d);
        smem[slen[4:0]] = {(sof != 0), d};
        slen++;
    endtask

    task automatic drive(input int de, input int first, input int drop);
        tim_de    = (de != 0);
        tim_first = (first != 0);
        if (head < slen && drop == 0) begin
            in_valid = 1'b1;
            in_sof   = smem[head[4:0]][24];
            in_data  = smem[head[4:0]][23:0];
        end else begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            in_data  = '0;
        end
    endtask

    task automatic step(input int de, input int first, input int drop);
        logic popped;
        @(negedge clk);
        drive(de, first, drop);
        #1;
        popped = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (popped) head++;
    endtask

    task automatic px(input int first, input int drop, input logic [31:0] erg,
                      input int elk, input int eerr);
        step(1, first, drop);
        chk("px_rgb",  32'(rgb),       erg);
        chk("px_de",   32'(rgb_de),    32'd1);
        chk("px_lock", 32'(locked),    32'(elk));
        chk("px_err",  32'(err_pulse), 32'(eerr));
    endtask

    task automatic blank(input int n, input int elk);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 0);
            chk("bl_rgb",  32'(rgb),       32'd0);
            chk("bl_de",   32'(rgb_de),    32'd0);
            chk("bl_lock", 32'(locked),    32'(elk));
            chk("bl_err",  32'(err_pulse), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        pixel_rst = 1'b0;
        clr();
        push(0, 24'hAA0001); push(0, 24'hAA0002); push(0, 24'hAA0003);
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(i));
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(i));
        drive(0, 0, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rgb",   32'(rgb),       32'd0);
        chk("rst_de",    32'(rgb_de),    32'd0);
        chk("rst_lock",  32'(locked),    32'd0);
        chk("rst_err",   32'(err_pulse), 32'd0);
        chk("rst_cnt",   32'(err_count), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        pixel_rst = 1'b1;
        #1;
        chk("sync_ready", 32'(in_ready), 32'd1);

        // stale discard, then two nominal frames
        blank(3, 0);
        chk("stale_head", 32'(head), 32'd3);
        blank(2, 0);
        px(1, 0, 32'd1, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(i), 1, 0);
        blank(2, 1);
        px(1, 0, 32'd1, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(i), 1, 0);
        blank(2, 1);
        chk("nom_cnt", 32'(err_count), 32'd0);

        // underflow at pixel 5
        clr();
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(i));
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(32'h10 + i));
        px(1, 0, 32'd1, 1, 0);
        px(0, 0, 32'd2, 1, 0);
        px(0, 0, 32'd3, 1, 0);
        px(0, 0, 32'd4, 1, 0);
        px(0, 1, 32'd0, 0, 1);
        px(0, 0, 32'd0, 0, 0);
        px(0, 0, 32'd0, 0, 0);
        px(0, 0, 32'd0, 0, 0);
        blank(2, 0);
        px(1, 0, 32'h11, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(32'h10 + i), 1, 0);
        blank(2, 1);
        chk("uf_cnt", 32'(err_count), 32'd1);

        // short stream frame (7 pixels)
        clr();
        for (int i = 1; i <= 7; i++) push(i == 1, 24'(32'h20 + i));
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(32'h30 + i));
        px(1, 0, 32'h21, 1, 0);
        for (int i = 2; i <= 7; i++) px(0, 0, 32'(32'h20 + i), 1, 0);
        px(0, 0, 32'd0, 0, 1);
        blank(2, 0);
        px(1, 0, 32'h31, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(32'h30 + i), 1, 0);
        blank(2, 1);
        chk("short_cnt", 32'(err_count), 32'd2);

        // long stream frame (9 pixels)
        clr();
        for (int i = 1; i <= 9; i++) push(i == 1, 24'(32'h40 + i));
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(32'h50 + i));
        px(1, 0, 32'h41, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(32'h40 + i), 1, 0);
        blank(2, 1);
        px(1, 0, 32'd0, 0, 1);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'd0, 0, 0);
        chk("long_head", 32'(head), 32'd9);
        blank(2, 0);
        px(1, 0, 32'h51, 1, 0);
        for (int i = 2; i <= 8; i++) px(0, 0, 32'(32'h50 + i), 1, 0);
        blank(2, 1);
        chk("long_cnt", 32'(err_count), 32'd3);

        // 300 forced underflows in WAIT_FRAME: count saturates at 255
        clr();
        push(1, 24'h000077);
        for (int i = 1; i <= 300; i++) begin
            step(0, 0, 0);
            step(1, 1, 1);
            chk("sat_pulse", 32'(err_pulse), 32'd1);
            if (i == 10)  chk("sat_cnt10",  32'(err_count), 32'd13);
            if (i == 252) chk("sat_cnt252", 32'(err_count), 32'd255);
        end
        chk("sat_cnt", 32'(err_count), 32'd255);

        // asynchronous reset mid-frame at pixel 3
        clr();
        for (int i = 1; i <= 8; i++) push(i == 1, 24'(32'h60 + i));
        blank(1, 0);
        px(1, 0, 32'h61, 1, 0);
        px(0, 0, 32'h62, 1, 0);
        @(negedge clk);
        drive(1, 0, 0);
        #2;
        pixel_rst = 1'b0;
        #1;
        chk("mid_rgb",   32'(rgb),       32'd0);
        chk("mid_de",    32'(rgb_de),    32'd0);
        chk("mid_lock",  32'(locked),    32'd0);
        chk("mid_err",   32'(err_pulse), 32'd0);
        chk("mid_cnt",   32'(err_count), 32'd0);
        chk("mid_ready", 32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        chk("hold_rgb", 32'(rgb),    32'd0);
        chk("hold_de",  32'(rgb_de), 32'd0);
        chk("hold_head", 32'(head),  32'd2);
        @(negedge clk);
        pixel_rst = 1'b1;
        blank(1, 0);
        chk("post_cnt",  32'(err_count), 32'd0);
        chk("post_head", 32'(head),      32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
